// File: rtl/reorder_buffer_pkg.sv
// Shared types and default sizing for the reorder buffer.
package reorder_buffer_pkg;

  localparam int PKG_NUM_REG   = 32;
  localparam int PKG_ROB_DEPTH = 16;
  localparam int PKG_REG_SIZE  = $clog2(PKG_NUM_REG);

  // One ROB slot; physical tags carry one extra bit over the architectural index.
  typedef struct packed {
    logic                    valid;
    logic                    done;
    logic [PKG_REG_SIZE-1:0] rd;
    logic [PKG_REG_SIZE:0]   prd_old;
    logic [PKG_REG_SIZE:0]   prd_new;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order reorder buffer: allocates renamed instructions at the tail, marks
// them done on writeback, and retires the oldest done entry, returning its old
// physical register to the rename free pool.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  // NUM_REG must match the package so the entry struct widths line up.
  parameter int NUM_REG   = PKG_NUM_REG,
  parameter int ROB_DEPTH = PKG_ROB_DEPTH,
  localparam int REG_SIZE = $clog2(NUM_REG),
  localparam int TAG_W    = $clog2(ROB_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic [REG_SIZE-1:0] rd_A,
  input  logic [REG_SIZE:0]   prd_A_old,
  input  logic [REG_SIZE:0]   prd_A_new,
  output logic [TAG_W-1:0]    rob_tag,
  output logic                rob_full,
  output logic                rob_empty,
  input  logic                complete_valid,
  input  logic [TAG_W-1:0]    complete_tag,
  input  logic                commit_ready,
  output logic                commit_free,
  output logic [REG_SIZE:0]   prd_free,
  output logic                commit_valid,
  output logic [REG_SIZE-1:0] commit_rd,
  output logic [REG_SIZE:0]   commit_prd
);

  rob_entry_t       r_rob [ROB_DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [TAG_W:0]   r_count;

  rob_entry_t w_head_entry;
  logic       w_alloc;
  logic       w_commit;

  assign w_head_entry = r_rob[r_head];

  // Full/empty come from the registered count only, so a commit in the same
  // cycle never opens a slot for a simultaneous allocation.
  assign rob_full  = (r_count == (TAG_W+1)'(ROB_DEPTH));
  assign rob_empty = (r_count == '0);
  assign rob_tag   = r_tail;

  assign w_alloc  = alloc_valid & ~rob_full;
  // Reset gating keeps a stale done head from pulsing a free during reset.
  assign w_commit = ~rst & w_head_entry.valid & w_head_entry.done & commit_ready;

  assign commit_valid = w_commit;
  assign commit_free  = w_commit & (w_head_entry.rd != '0);
  assign prd_free     = commit_free ? w_head_entry.prd_old : '0;
  assign commit_rd    = w_commit ? w_head_entry.rd : '0;
  assign commit_prd   = w_commit ? w_head_entry.prd_new : '0;

  // Entry array, pointers and occupancy; commit clears last so it wins over a
  // redundant completion to the retiring head.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        r_rob[i] <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_alloc) begin
        r_rob[r_tail] <= '{valid: 1'b1, done: 1'b0, rd: rd_A,
                           prd_old: prd_A_old, prd_new: prd_A_new};
        r_tail        <= r_tail + TAG_W'(1);
      end
      if (complete_valid && r_rob[complete_tag].valid) begin
        r_rob[complete_tag].done <= 1'b1;
      end
      if (w_commit) begin
        r_rob[r_head] <= '0;
        r_head        <= r_head + TAG_W'(1);
      end
      unique case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer against a queue-based program-order model.
module tb_reorder_buffer;

  localparam int D  = 16;
  localparam int RS = 5;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid;
  logic [RS-1:0] rd_A;
  logic [RS:0]   prd_A_old;
  logic [RS:0]   prd_A_new;
  logic [TW-1:0] rob_tag;
  logic          rob_full;
  logic          rob_empty;
  logic          complete_valid;
  logic [TW-1:0] complete_tag;
  logic          commit_ready;
  logic          commit_free;
  logic [RS:0]   prd_free;
  logic          commit_valid;
  logic [RS-1:0] commit_rd;
  logic [RS:0]   commit_prd;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .rd_A(rd_A), .prd_A_old(prd_A_old), .prd_A_new(prd_A_new),
    .rob_tag(rob_tag), .rob_full(rob_full), .rob_empty(rob_empty),
    .complete_valid(complete_valid), .complete_tag(complete_tag),
    .commit_ready(commit_ready), .commit_free(commit_free), .prd_free(prd_free),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_prd(commit_prd)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: in-flight instructions in program order, oldest first.
  typedef struct {
    int rd;
    int old_p;
    int new_p;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;

  logic          exp_cv, exp_cf, exp_full, exp_empty;
  logic [RS:0]   exp_pf, exp_cprd;
  logic [RS-1:0] exp_crd;
  logic [TW-1:0] exp_tag;

  // Derive expected outputs from the model and the currently driven inputs.
  task automatic settle();
    #1;
    exp_empty = (q.size() == 0);
    exp_full  = (q.size() == D);
    exp_tag   = TW'((m_head + q.size()) % D);
    exp_cv    = !rst && commit_ready && q.size() > 0 && q[0].done;
    exp_cf    = exp_cv && q[0].rd != 0;
    exp_pf    = exp_cf ? (RS+1)'(q[0].old_p) : '0;
    exp_crd   = exp_cv ? RS'(q[0].rd) : '0;
    exp_cprd  = exp_cv ? (RS+1)'(q[0].new_p) : '0;
  endtask

  // Advance one clock and apply the same inputs to the model.
  task automatic tick();
    int  n;
    bit  do_commit;
    int  idx;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_head = 0;
    end else begin
      n = q.size();
      do_commit = commit_ready && n > 0 && q[0].done;
      if (complete_valid) begin
        idx = (int'(complete_tag) - m_head + D) % D;
        if (idx < n) q[idx].done = 1'b1;
      end
      if (do_commit) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % D;
      end
      if (alloc_valid && n < D)
        q.push_back('{rd: int'(rd_A), old_p: int'(prd_A_old), new_p: int'(prd_A_new), done: 1'b0});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; rd_A = '0; prd_A_old = '0; prd_A_new = '0;
    complete_valid = 0; complete_tag = '0; commit_ready = 1;
  endtask

  task automatic do_reset();
    rst = 1; idle_inputs();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    settle();
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cycle_cv got=%b exp=0", commit_valid); end
    tick();
    rst = 0;
    settle();
    n_checks++; if (rob_empty !== 1'b1) begin n_errors++; $display("FAIL reset_empty got=%b exp=1", rob_empty); end
    n_checks++; if (rob_full !== 1'b0) begin n_errors++; $display("FAIL reset_full got=%b exp=0", rob_full); end
    n_checks++; if (rob_tag !== 4'd0) begin n_errors++; $display("FAIL reset_tag got=%0d exp=0", rob_tag); end
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL reset_cv got=%b exp=0", commit_valid); end
    n_checks++; if (prd_free !== 6'd0) begin n_errors++; $display("FAIL reset_prd_free got=%0d exp=0", prd_free); end
    n_checks++; if (commit_free !== 1'b0) begin n_errors++; $display("FAIL reset_cf got=%b exp=0", commit_free); end
  endtask

  task automatic test_single();
    do_reset();
    alloc_valid = 1; rd_A = 5'd5; prd_A_old = 6'd5; prd_A_new = 6'd32;
    tick();
    alloc_valid = 0; complete_valid = 1; complete_tag = 4'd0;
    settle();
    n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_cv got=%b exp=0", commit_valid); end
    tick();
    complete_valid = 0;
    settle();
    n_checks++; if (commit_valid !== 1'b1) begin n_errors++; $display("FAIL single_cv got=%b exp=1", commit_valid); end
    n_checks++; if (commit_free !== 1'b1) begin n_errors++; $display("FAIL single_cf got=%b exp=1", commit_free); end
    n_checks++; if (prd_free !== 6'd5) begin n_errors++; $display("FAIL single_prd_free got=%0d exp=5", prd_free); end
    n_checks++; if (commit_rd !== 5'd5) begin n_errors++; $display("FAIL single_rd got=%0d exp=5", commit_rd); end
    n_checks++; if (commit_prd !== 6'd32) begin n_errors++; $display("FAIL single_prd got=%0d exp=32", commit_prd); end
    tick();
    settle();
    n_checks++; if (rob_empty !== 1'b1) begin n_errors++; $display("FAIL single_empty_after got=%b exp=1", rob_empty); end
  endtask

  task automatic test_x0();
    alloc_valid = 1; rd_A = 5'd0; prd_A_old = 6'd0; prd_A_new = 6'd0;
    tick();
    alloc_valid = 0; complete_valid = 1; complete_tag = exp_tag;
    settle();
    complete_tag = TW'((m_head) % D);
    tick();
    complete_valid = 0;
    settle();
    n_checks++; if (commit_valid !== 1'b1) begin n_errors++; $display("FAIL x0_cv got=%b exp=1", commit_valid); end
    n_checks++; if (commit_free !== 1'b0) begin n_errors++; $display("FAIL x0_cf got=%b exp=0", commit_free); end
    n_checks++; if (prd_free !== 6'd0) begin n_errors++; $display("FAIL x0_prd_free got=%0d exp=0", prd_free); end
    tick();
  endtask

  task automatic test_ooo();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc_valid = 1; rd_A = RS'(i + 1); prd_A_old = 6'(i + 10); prd_A_new = 6'(i + 40);
      tick();
    end
    alloc_valid = 0;
    for (int t = 2; t >= 0; t--) begin
      complete_valid = 1; complete_tag = TW'(t);
      settle();
      n_checks++; if (commit_valid !== 1'b0) begin n_errors++; $display("FAIL ooo_wait_%0d got=%b exp=0", t, commit_valid); end
      tick();
    end
    complete_valid = 0;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_checks++;
      if (commit_valid !== 1'b1 || commit_rd !== RS'(i + 1) || prd_free !== 6'(i + 10)) begin
        n_errors++;
        $display("FAIL ooo_commit_%0d got cv=%b rd=%0d pf=%0d exp cv=1 rd=%0d pf=%0d",
                 i, commit_valid, commit_rd, prd_free, i + 1, i + 10);
      end
      tick();
    end
    settle();
    n_checks++; if (rob_empty !== 1'b1) begin n_errors++; $display("FAIL ooo_empty got=%b exp=1", rob_empty); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    commit_ready = 0;
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1; rd_A = RS'(i); prd_A_old = 6'(i + 1); prd_A_new = 6'(63 - i);
      settle();
      n_checks++; if (rob_tag !== exp_tag) begin n_errors++; $display("FAIL fill_tag_%0d got=%0d exp=%0d", i, rob_tag, exp_tag); end
      tick();
    end
    rd_A = 5'd31; prd_A_old = 6'd33; prd_A_new = 6'd34;
    settle();
    n_checks++; if (rob_full !== 1'b1) begin n_errors++; $display("FAIL full_flag got=%b exp=1", rob_full); end
    n_checks++; if (rob_tag !== 4'd0) begin n_errors++; $display("FAIL full_tag got=%0d exp=0", rob_tag); end
    tick();
    alloc_valid = 0;
    settle();
    n_checks++; if (rob_tag !== 4'd0 || rob_full !== 1'b1) begin n_errors++; $display("FAIL full_refused got tag=%0d full=%b exp tag=0 full=1", rob_tag, rob_full); end
    for (int i = 0; i < D; i++) begin
      complete_valid = 1; complete_tag = TW'(i);
      tick();
    end
    complete_valid = 0;
    commit_ready = 1;
    for (int i = 0; i < D; i++) begin
      alloc_valid = 1; rd_A = RS'($urandom_range(0, 31)); prd_A_old = 6'($urandom_range(0, 63)); prd_A_new = 6'($urandom_range(0, 63));
      settle();
      n_checks++;
      if (commit_valid !== 1'b1 || prd_free !== exp_pf || commit_rd !== RS'(i) || rob_full !== exp_full || rob_tag !== exp_tag) begin
        n_errors++;
        $display("FAIL drain_%0d got cv=%b pf=%0d rd=%0d full=%b tag=%0d exp cv=1 pf=%0d rd=%0d full=%b tag=%0d",
                 i, commit_valid, prd_free, commit_rd, rob_full, rob_tag, exp_pf, i, exp_full, exp_tag);
      end
      tick();
    end
    alloc_valid = 0;
    settle();
    n_checks++; if (rob_tag !== 4'd15 || rob_full !== 1'b0 || commit_valid !== 1'b0) begin
      n_errors++; $display("FAIL drain_end got tag=%0d full=%b cv=%b exp tag=15 full=0 cv=0", rob_tag, rob_full, commit_valid);
    end
  endtask

  task automatic test_backpressure_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      alloc_valid = 1; rd_A = RS'(i + 3); prd_A_old = 6'(i + 20); prd_A_new = 6'(i + 50);
      tick();
    end
    alloc_valid = 0; complete_valid = 1; complete_tag = 4'd0; commit_ready = 0;
    tick();
    complete_valid = 0;
    for (int c = 0; c < 3; c++) begin
      settle();
      n_checks++;
      if (commit_valid !== 1'b0 || commit_free !== 1'b0 || prd_free !== 6'd0 || commit_rd !== 5'd0 || rob_tag !== 4'd5) begin
        n_errors++;
        $display("FAIL bp_hold_%0d got cv=%b cf=%b pf=%0d rd=%0d tag=%0d exp all0 tag=5", c, commit_valid, commit_free, prd_free, commit_rd, rob_tag);
      end
      tick();
    end
    rst = 1; commit_ready = 1;
    settle();
    n_checks++; if (commit_valid !== 1'b0 || commit_free !== 1'b0) begin
      n_errors++; $display("FAIL rst_cycle got cv=%b cf=%b exp 0 0", commit_valid, commit_free);
    end
    tick();
    rst = 0;
    settle();
    n_checks++; if (rob_empty !== 1'b1 || rob_tag !== 4'd0 || commit_free !== 1'b0) begin
      n_errors++; $display("FAIL rst_after got empty=%b tag=%0d cf=%b exp 1 0 0", rob_empty, rob_tag, commit_free);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      alloc_valid    = ($urandom_range(0, 99) < 60);
      rd_A           = RS'($urandom_range(0, 31));
      prd_A_old      = 6'($urandom_range(0, 63));
      prd_A_new      = 6'($urandom_range(0, 63));
      complete_valid = ($urandom_range(0, 99) < 70);
      complete_tag   = TW'($urandom_range(0, D - 1));
      commit_ready   = ($urandom_range(0, 99) < 75);
      settle();
      n_checks++;
      if (commit_valid !== exp_cv || commit_free !== exp_cf || prd_free !== exp_pf ||
          commit_rd !== exp_crd || commit_prd !== exp_cprd || rob_full !== exp_full ||
          rob_empty !== exp_empty || rob_tag !== exp_tag) begin
        n_errors++;
        $display("FAIL rand_%0d got cv=%b cf=%b pf=%0d rd=%0d prd=%0d full=%b empty=%b tag=%0d exp cv=%b cf=%b pf=%0d rd=%0d prd=%0d full=%b empty=%b tag=%0d",
                 c, commit_valid, commit_free, prd_free, commit_rd, commit_prd, rob_full, rob_empty, rob_tag,
                 exp_cv, exp_cf, exp_pf, exp_crd, exp_cprd, exp_full, exp_empty, exp_tag);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_single();
    test_x0();
    test_ooo();
    test_full_wrap();
    test_backpressure_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

In-order reorder buffer directly downstream of the rename stage. It accepts one renamed instruction per cycle (architectural rd, old and new physical rd) into a circular queue. It marks entries done on execution completion and retires the oldest done entry each cycle. On retirement it returns the old physical register to the rename free pool via `prd_free`/`commit_free`, which closes the register-recycling loop.

## Interface
Parameters:
- `NUM_REG`, 32, architectural register count; `REG_SIZE = $clog2(NUM_REG)`; physical tags are `REG_SIZE+1` bits wide.
- `ROB_DEPTH`, 16, entry count; power of two, ≥2; `TAG_W = $clog2(ROB_DEPTH)`.

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock; all state updates on rising edge.
  - `rst`  in  1  reset.
- Allocation (from rename):
  - `alloc_valid`  in  1  rename presents an instruction this cycle.
  - `rd_A`  in  REG_SIZE  architectural destination.
  - `prd_A_old`  in  REG_SIZE+1  previous mapping of `rd_A`.
  - `prd_A_new`  in  REG_SIZE+1  newly allocated mapping.
  - `rob_tag`  out  TAG_W  tail index; the tag the presented instruction receives.
  - `rob_full`  out  1  no free entry; rename must stall.
  - `rob_empty`  out  1  no valid entries.
- Completion:
  - `complete_valid`  in  1  execution writeback.
  - `complete_tag`  in  TAG_W  entry to mark done.
- Commit:
  - `commit_ready`  in  1  downstream (rename free-pool port) accepts a retirement this cycle.
  - `commit_free`  out  1  retiring entry frees a physical register.
  - `prd_free`  out  REG_SIZE+1  physical register to free (old mapping).
  - `commit_valid`  out  1  an entry retires this cycle.
  - `commit_rd`  out  REG_SIZE  architectural rd of the retiring entry.
  - `commit_prd`  out  REG_SIZE+1  new mapping of the retiring entry.

## Operation
- Each entry holds `valid`, `done`, `rd`, `prd_old`, and `prd_new`. State also includes `head`, `tail` (TAG_W, wrap modulo ROB_DEPTH), and `count` (TAG_W+1).
- Allocation is accepted when `alloc_valid & ~rob_full`. The entry is written at `tail` with `valid=1`, `done=0`, and `tail` increments. When `alloc_valid & rob_full`, the request is ignored and no state changes.
- Completion happens when `complete_valid` is high and entry `complete_tag` is valid: its `done` bit is set to 1. Completion to an invalid entry is ignored. A repeated completion is harmless.
- Commit: `commit_valid = valid[head] & done[head] & commit_ready`. On a commit, the entry is cleared and `head` increments.
- `commit_free = commit_valid & (rd[head] != 0)`. Architectural x0 never frees a register. `prd_free = commit_free ? prd_old[head] : 0`.
- `commit_rd` and `commit_prd` equal the head fields when `commit_valid`, and 0 otherwise.
- `count` is updated as +1 on allocate only, −1 on commit only, and unchanged on both or neither.
- `rob_full = (count == ROB_DEPTH)` and `rob_empty = (count == 0)`. Both depend on registered count only, with no same-cycle bypass.

## Timing
- Reset: `head`, `tail`, and `count` are 0, and all `valid`/`done` bits are 0. After reset, `rob_tag=0`, `rob_full=0`, `rob_empty=1`, and all commit outputs are 0.
- `rst` asserted mid-operation discards all entries at the next edge. No commit outputs assert during the reset cycle.
- All outputs are combinational from registered state plus `commit_ready`. There are no combinational paths from `alloc_*` or `complete_*` to any output.
- Completion becomes visible one cycle later. Minimum allocate-to-commit latency is 2 cycles: allocate at edge N, complete during cycle N+1 (done set at edge N+1), commit asserted during cycle N+2.
- Full with simultaneous commit: the allocation is still refused, because full is registered. Occupancy drops to ROB_DEPTH−1.
- Empty with allocate: the new entry cannot commit in the same cycle.
- Allocate and commit may target the same index when `head==tail` after wrap. This occurs only when full (alloc refused) or empty (entry invalid), so no conflict arises.
- `commit_ready` low holds the head entry; outputs drop to 0 and no state advances.

## Structure
- Shared package or `constants.sv`: `rob_entry_t` packed struct (`valid`, `done`, `rd`, `prd_old`, `prd_new`) and the default `ROB_DEPTH`. `REG_SIZE` is derived as in rename.
- Single module. Entry array and pointers are inline. No sub-module is warranted; pointer wrap is natural power-of-two overflow.

## Test plan
- Reset: assert `rst` 1 cycle. Expect `rob_empty=1`, `rob_full=0`, `rob_tag=0`, `commit_valid=0`, `prd_free=0`.
- Single instruction: allocate rd=5, old=5, new=32. Complete tag 0 the next cycle, with `commit_ready=1`. Two cycles after allocation expect `commit_valid=1`, `commit_free=1`, `prd_free=5`, `commit_rd=5`, `commit_prd=32`, then `rob_empty=1`.
- x0 destination: allocate rd=0, old=0, new=0, then complete. Expect `commit_valid=1`, `commit_free=0`, `prd_free=0`.
- Out-of-order completion: allocate tags 0,1,2, then complete 2, 1, 0. Expect no commit until tag 0 is done, then commits in order 0,1,2 on consecutive cycles.
- Full and wrap: allocate 16 entries. Expect `rob_full=1` and a 17th allocation ignored (`rob_tag` stays 0). Complete all and commit 16, while allocating in the same cycles as commits. Expect `count` steady, correct `prd_free` sequence, and `tail` wraps to 0.
- Backpressure and mid-op reset: hold `commit_ready=0` with head done. Expect commit outputs at 0 and the entry retained. Assert `rst` with 5 valid entries; the next cycle expect `rob_empty=1` and no `commit_free` pulse.
